// File: rtl/wb_stage_if.sv
// MEM->WB stage bus: memory-stage inputs, decode-stage register reads and writeback status.
// The master modport is the surrounding pipeline. The slave modport is the writeback stage.
interface wb_stage_if;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_index_i;
  logic        mem_rd_we_i;
  logic        mem_load_i;
  logic [31:0] mem_alu_result_i;
  logic [31:0] mem_rdata_i;
  logic        stall_i;
  logic [4:0]  rs1_index_i;
  logic [4:0]  rs2_index_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_index_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [63:0] instret_o;

  modport master (
    output mem_valid_i, mem_rd_index_i, mem_rd_we_i, mem_load_i,
           mem_alu_result_i, mem_rdata_i, stall_i, rs1_index_i, rs2_index_i,
    input  rs1_data_o, rs2_data_o, wb_valid_o, wb_rd_index_o, wb_data_o,
           wb_we_o, instret_o
  );

  modport slave (
    input  mem_valid_i, mem_rd_index_i, mem_rd_we_i, mem_load_i,
           mem_alu_result_i, mem_rdata_i, stall_i, rs1_index_i, rs2_index_i,
    output rs1_data_o, rs2_data_o, wb_valid_o, wb_rd_index_o, wb_data_o,
           wb_we_o, instret_o
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: one MEM/WB register, 31x32 register file with write-through bypass, retire counter.
// One cycle of latency. A stall freezes MEM/WB and blocks commit; there is no other backpressure.
module wb_stage (
  input  logic      clk_i,
  input  logic      reset_i,
  wb_stage_if.slave bus
);
  logic        valid_q, valid_d;
  logic [4:0]  rd_index_q, rd_index_d;
  logic        rd_we_q, rd_we_d;
  logic [31:0] data_q, data_d;
  logic [63:0] instret_q, instret_d;
  logic [31:0] regs_q [31:1];
  logic [31:0] regs_d [31:1];
  logic        commit;
  logic        wr_en;

  always_comb begin
    valid_d    = valid_q;
    rd_index_d = rd_index_q;
    rd_we_d    = rd_we_q;
    data_d     = data_q;
    instret_d  = instret_q;
    regs_d     = regs_q;

    commit = valid_q & ~bus.stall_i;
    wr_en  = valid_q & rd_we_q & (rd_index_q != 5'd0);

    if (!bus.stall_i) begin
      valid_d    = bus.mem_valid_i;
      rd_index_d = bus.mem_rd_index_i;
      rd_we_d    = bus.mem_rd_we_i;
      // Load/ALU select is resolved here so MEM/WB only ever holds the final value.
      data_d     = bus.mem_load_i ? bus.mem_rdata_i : bus.mem_alu_result_i;
    end

    if (commit) begin
      instret_d = instret_q + 64'd1;
      for (int i = 1; i < 32; i++) begin
        if (wr_en && (rd_index_q == 5'(i))) begin
          regs_d[i] = data_q;
        end
      end
    end
  end

  // Read ports: x0 is hardwired, and a held write bypasses the array even while stalled.
  always_comb begin
    bus.rs1_data_o = 32'd0;
    bus.rs2_data_o = 32'd0;
    for (int i = 1; i < 32; i++) begin
      if (bus.rs1_index_i == 5'(i)) bus.rs1_data_o = regs_q[i];
      if (bus.rs2_index_i == 5'(i)) bus.rs2_data_o = regs_q[i];
    end
    if (wr_en && (rd_index_q == bus.rs1_index_i)) bus.rs1_data_o = data_q;
    if (wr_en && (rd_index_q == bus.rs2_index_i)) bus.rs2_data_o = data_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      rd_index_q <= 5'd0;
      rd_we_q    <= 1'b0;
      data_q     <= 32'd0;
      instret_q  <= 64'd0;
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      valid_q    <= valid_d;
      rd_index_q <= rd_index_d;
      rd_we_q    <= rd_we_d;
      data_q     <= data_d;
      instret_q  <= instret_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.wb_valid_o    = valid_q;
  assign bus.wb_rd_index_o = rd_index_q;
  assign bus.wb_data_o     = data_q;
  assign bus.wb_we_o       = wr_en;
  assign bus.instret_o     = instret_q;
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port mem_valid_i, input, 1, the memory stage presents an instruction this cycle.
REQ-004 SHALL have port mem_rd_index_i, input, 5, destination register index from the memory stage.
REQ-005 SHALL have port mem_rd_we_i, input, 1, the instruction writes its destination register.
REQ-006 SHALL have port mem_load_i, input, 1, the instruction is a load, so result = mem_rdata_i.
REQ-007 SHALL have port mem_alu_result_i, input, 32, ALU result forwarded through the memory stage.
REQ-008 SHALL have port mem_rdata_i, input, 32, sign/zero-extended load data from the memory stage.
REQ-009 SHALL have port stall_i, input, 1, freezes the MEM/WB register and suppresses commit.
REQ-010 SHALL have ports rs1_index_i and rs2_index_i, input, 5 each, decode-stage read indices.
REQ-011 SHALL have ports rs1_data_o and rs2_data_o, output, 32 each, register read data including bypass.
REQ-012 SHALL have port wb_valid_o, output, 1, the MEM/WB register holds a valid instruction.
REQ-013 SHALL have port wb_rd_index_o, output, 5, destination index held in MEM/WB (for hazard logic).
REQ-014 SHALL have port wb_data_o, output, 32, selected writeback value held in MEM/WB.
REQ-015 SHALL have port wb_we_o, output, 1, = wb_valid_o & held rd_we & (wb_rd_index_o != 0), combinational.
REQ-016 SHALL have port instret_o, output, 64, count of committed instructions.

Function
REQ-017 SHALL capture the MEM/WB register (valid, rd_index, rd_we, data) on each rising edge where stall_i = 0; when stall_i = 1, all held fields SHALL be unchanged.
REQ-018 SHALL capture data as mem_rdata_i when mem_load_i = 1, else mem_alu_result_i; the select SHALL be resolved at capture time.
REQ-019 SHALL define commit as wb_valid_o = 1 and stall_i = 0 in the same cycle; commit SHALL happen exactly once per instruction.
REQ-020 On commit with wb_we_o = 1, SHALL write wb_data_o into register wb_rd_index_o at that rising edge.
REQ-021 SHALL hold x0 at 0 permanently; writes to index 0 SHALL be discarded.
REQ-022 SHALL implement 31 x 32-bit registers (x1..x31) with two asynchronous read ports.
REQ-023 SHALL drive rsN_data_o = 0 when rsN_index_i = 0.
REQ-024 When wb_we_o = 1 and wb_rd_index_o = rsN_index_i, SHALL drive rsN_data_o = wb_data_o (write-through bypass), independent of stall_i.
REQ-025 Otherwise, SHALL drive rsN_data_o from the register array.
REQ-026 SHALL increment instret_o by 1 on every commit, regardless of rd_we, and SHALL wrap from 2^64-1 to 0.
REQ-027 SHALL impose no latency beyond one register stage: MEM inputs are visible on wb_* outputs in the cycle after capture.
REQ-028 mem_valid_i = 0 at capture SHALL load a bubble: wb_valid_o = 0, no write, no count.

Reset
REQ-029 On reset_i = 1, SHALL immediately clear wb_valid_o, wb_rd_index_o, wb_data_o, held rd_we, instret_o and x1..x31 to 0, without waiting for a clock edge.
REQ-030 A pending uncommitted instruction in MEM/WB at reset SHALL be discarded, with no write and no count.
REQ-031 After reset_i deasserts, the first capture SHALL occur on the next rising edge where stall_i = 0.

Verification
REQ-032 Bench SHALL load x5 with rd=5, alu=0x0000_1234, load=0, valid=1, then idle -> wb_data_o=0x1234 next cycle; after the commit edge, rs1_index_i=5 reads 0x1234; instret_o=1.
REQ-033 Bench SHALL apply a load with rd=7, rdata=0xFFFF_FF80, alu=0xDEAD_BEEF -> wb_data_o=0xFFFF_FF80, x7=0xFFFF_FF80.
REQ-034 Bench SHALL apply rd=0, we=1, alu=0xFFFF_FFFF -> wb_we_o=0, rs2 index 0 reads 0, and instret_o still increments.
REQ-035 Bench SHALL hold wb_valid_o=1 with rd=3, data=0xA5A5_A5A5 and stall_i=1 for 3 cycles, then release -> rs1_index_i=3 returns 0xA5A5_A5A5 via bypass throughout, the array is written once, and instret_o increments by exactly 1.
REQ-036 Bench SHALL preload instret_o to 0xFFFF_FFFF_FFFF_FFFF by forcing, then commit one instruction -> instret_o=0.
REQ-037 Bench SHALL assert reset_i mid-cycle with a pending write to x9 -> all outputs are 0 before the next edge, and x9 reads 0 after reset.
